// File: rtl/regfile_pkg.sv
// Shared types, default sizes and address helpers for the parametrised register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } regfile_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 64;

    // Depth need not be a power of two, so the top of the address space may be unpopulated.
    function automatic logic addr_valid(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: sweeps every register to zero, then raises ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEF_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              ready_o
);

    // state | meaning
    // CLEAR | writing zero to clr_ptr each cycle; port accesses ignored
    // RUN   | clear finished; register file serves reads and writes

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    regfile_state_e    state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we_o  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_o = 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = RUN;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    assign clr_addr_o = clr_ptr_q;
    assign ready_o    = (state_q == RUN);

endmodule

// File: rtl/register_file_p.sv
// Parametrised 2-read/1-write register file with hardware clear and optional zero register.
// Define REGFILE_BYPASS_EN for write-first (same-cycle write forwarded to the read ports).
module register_file_p
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              write,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  rs,
    output logic [WIDTH-1:0]  rt,
    output logic              ready
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;

    logic [WIDTH-1:0]  rs_q, rs_d;
    logic [WIDTH-1:0]  rt_q, rt_d;
    logic              wr_ok;
    logic              rs_ok;
    logic              rt_ok;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clock      (clock),
        .reset      (reset),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .ready_o    (ready)
    );

    assign wr_ok = ready && write && addr_valid(32'(rd_addr), DEPTH) && !is_zero_reg(rd_addr);
    assign rs_ok = addr_valid(32'(rs_addr), DEPTH) && !is_zero_reg(rs_addr);
    assign rt_ok = addr_valid(32'(rt_addr), DEPTH) && !is_zero_reg(rt_addr);

    // The sequencer owns the write port until ready; nothing is written while reset is held.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = rd_addr;
        mem_wdata = data_in;
        if (reset) begin
            mem_we = 1'b0;
        end else if (!ready) begin
            mem_we    = clr_we;
            mem_addr  = clr_addr;
            mem_wdata = '0;
        end else begin
            mem_we = wr_ok;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        rs_d = '0;
        rt_d = '0;
        if (ready) begin
            if (rs_ok) begin
                rs_d = mem_q[rs_addr];
            end
            if (rt_ok) begin
                rt_d = mem_q[rt_addr];
            end
`ifdef REGFILE_BYPASS_EN
            // wr_ok already excludes invalid and hardwired-zero targets.
            if (wr_ok && (rd_addr == rs_addr)) begin
                rs_d = data_in;
            end
            if (wr_ok && (rd_addr == rt_addr)) begin
                rt_d = data_in;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rs_q <= '0;
            rt_q <= '0;
        end else begin
            rs_q <= rs_d;
            rt_q <= rt_d;
        end
    end

    assign rs = rs_q;
    assign rt = rt_q;

endmodule

// File: tb/tb_register_file_p.sv
// Directed bench for register_file_p: a 64-deep instance and a 40-deep (odd depth) instance.
module tb_register_file_p;

    localparam int W = 32;

    logic          clock;
    logic          reset;

    logic [5:0]    rs_addr, rt_addr, rd_addr;
    logic          write;
    logic [W-1:0]  data_in;
    logic [W-1:0]  rs, rt;
    logic          ready;

    logic [5:0]    rs_addr40, rt_addr40, rd_addr40;
    logic          write40;
    logic [W-1:0]  data_in40;
    logic [W-1:0]  rs40, rt40;
    logic          ready40;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int seen_ready;

    register_file_p #(.WIDTH(W), .DEPTH(64)) dut (
        .clock   (clock),
        .reset   (reset),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rd_addr (rd_addr),
        .write   (write),
        .data_in (data_in),
        .rs      (rs),
        .rt      (rt),
        .ready   (ready)
    );

    register_file_p #(.WIDTH(W), .DEPTH(40)) dut40 (
        .clock   (clock),
        .reset   (reset),
        .rs_addr (rs_addr40),
        .rt_addr (rt_addr40),
        .rd_addr (rd_addr40),
        .write   (write40),
        .data_in (data_in40),
        .rs      (rs40),
        .rt      (rt40),
        .ready   (ready40)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        rs_addr = '0; rt_addr = '0; rd_addr = '0; write = 1'b0; data_in = '0;
        rs_addr40 = '0; rt_addr40 = '0; rd_addr40 = '0; write40 = 1'b0; data_in40 = '0;

        // Reset and full clear sweep
        step();
        reset = 1'b0;
        chk("reset_ready", {31'b0, ready}, 32'd0);
        chk("reset_rs", rs, 32'd0);
        chk("reset_rt", rt, 32'd0);
        wait_ready(cyc);
        chk("clear_cycles", cyc, 32'd64);
        chk("ready40_after_clear", {31'b0, ready40}, 32'd1);

        for (int i = 0; i < 64; i++) begin
            rs_addr = 6'(i);
            rt_addr = 6'(63 - i);
            step();
            chk($sformatf("zero_rs_%0d", i), rs, 32'd0);
            chk($sformatf("zero_rt_%0d", 63 - i), rt, 32'd0);
        end

        // Basic write then read on both ports
        write = 1'b1; rd_addr = 6'd3; data_in = 32'd19;
        step();
        write = 1'b0; rs_addr = 6'd3; rt_addr = 6'd2;
        step();
        chk("basic_rs", rs, 32'd19);
        chk("basic_rt", rt, 32'd0);

        // Same-address read and write
        write = 1'b1; rd_addr = 6'd5; data_in = 32'd7;
        step();
        rs_addr = 6'd5; rt_addr = 6'd5; data_in = 32'd42;
        step();
        write = 1'b0;
`ifdef REGFILE_BYPASS_EN
        chk("rw_same_rs_first", rs, 32'd42);
        chk("rw_same_rt_first", rt, 32'd42);
`else
        chk("rw_same_rs_first", rs, 32'd7);
        chk("rw_same_rt_first", rt, 32'd7);
`endif
        step();
        chk("rw_same_rs_second", rs, 32'd42);
        chk("rw_same_rt_second", rt, 32'd42);

        // Hardwired zero register
        write = 1'b1; rd_addr = 6'd0; data_in = 32'hDEADBEEF; rs_addr = 6'd0; rt_addr = 6'd3;
        step();
        write = 1'b0;
        chk("zero_reg_bypass", rs, 32'd0);
        chk("other_port_during_zero_wr", rt, 32'd19);
        step();
        chk("zero_reg_after", rs, 32'd0);

        // Dirty a few registers, then reset mid-clear
        write = 1'b1; rd_addr = 6'd10; data_in = 32'hAB;
        step();
        rd_addr = 6'd63; data_in = 32'hCD;
        step();
        write = 1'b0; rs_addr = 6'd63; rt_addr = 6'd10;
        step();
        chk("pre_reset_rs63", rs, 32'hCD);
        chk("pre_reset_rt10", rt, 32'hAB);

        reset = 1'b1;
        step();
        reset = 1'b0;
        seen_ready = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ready) seen_ready++;
        end
        chk("ready_low_first_20", seen_ready, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
        while (!ready && cyc < 200) begin
            if (cyc == 30) begin
                write = 1'b1; rd_addr = 6'd3; data_in = 32'h77; rs_addr = 6'd3;
            end else begin
                write = 1'b0;
            end
            step();
            cyc++;
            if (cyc == 32) chk("rs_held_in_clear", rs, 32'd0);
        end
        write = 1'b0;
        chk("restart_clear_cycles", cyc, 32'd64);

        rs_addr = 6'd3; rt_addr = 6'd63;
        step();
        chk("cleared_rs3", rs, 32'd0);
        chk("cleared_rt63", rt, 32'd0);
        rs_addr = 6'd10; rt_addr = 6'd5;
        step();
        chk("cleared_rs10", rs, 32'd0);
        chk("cleared_rt5", rt, 32'd0);

        // Odd depth: out-of-range access on the 40-deep instance
        chk("ready40", {31'b0, ready40}, 32'd1);
        write40 = 1'b1; rd_addr40 = 6'd45; data_in40 = 32'h55; rs_addr40 = 6'd45; rt_addr40 = 6'd45;
        step();
        write40 = 1'b0;
        chk("oor_bypass_rs", rs40, 32'd0);
        step();
        chk("oor_read_rs", rs40, 32'd0);
        chk("oor_read_rt", rt40, 32'd0);

        write40 = 1'b1; rd_addr40 = 6'd39; data_in40 = 32'h99; rs_addr40 = 6'd39; rt_addr40 = 6'd38;
        step();
        write40 = 1'b0;
`ifdef REGFILE_BYPASS_EN
        chk("top_addr_same_cycle", rs40, 32'h99);
`else
        chk("top_addr_same_cycle", rs40, 32'd0);
`endif
        step();
        chk("top_addr_read", rs40, 32'h99);
        chk("below_top_read", rt40, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
